// File: rtl/alu_scheduler_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler.
//   - ALU op-code constants (0..7)
//   - scheduler FSM state encoding
//   - default latency constants and a small max helper used for counter sizing
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_NOR = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;
   localparam logic [2:0] ALU_ADD = 3'd5;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_MOD = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE_COMB = 3'd1,
      ST_MOD_RST    = 3'd2,
      ST_MOD_WAIT   = 3'd3,
      ST_RESP       = 3'd4
   } sched_state_t;

   localparam int unsigned DEF_COMB_WAIT      = 2;
   localparam int unsigned DEF_MOD_RST_CYCLES = 4;
   localparam int unsigned DEF_MOD_WAIT       = 512;

   function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                        input int unsigned z);
      int unsigned m;
      m = (x > y) ? x : y;
      return (m > z) ? m : z;
   endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin arbiter.
//   req[1:0]   in   request vector (bit N = requester N)
//   last_grant in   requester granted most recently (register lives in the caller)
//   enable     in   when low no grant is issued
//   grant[1:0] out  one-hot grant, all zero when disabled or nothing requested
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         // On a tie the requester that did not win last time goes first.
         if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
         else              grant = req;
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer in front of the shared ALU.
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid/ready/sel/a/b    two request channels (valid/ready)
//   rsp_valid/ready/id/result/err  single response channel, tagged by requester
//   alu_sel/a/b/reset, alu_result  ALU drive and result capture
// One operation is in flight at a time; ops 0-6 wait COMB_WAIT cycles, a mod
// pulses alu_reset for MOD_RST_CYCLES then waits MOD_WAIT cycles. A mod by
// zero never touches the ALU and answers with all-ones and rsp_err set.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned COMB_WAIT      = DEF_COMB_WAIT,
   parameter int unsigned MOD_RST_CYCLES = DEF_MOD_RST_CYCLES,
   parameter int unsigned MOD_WAIT       = DEF_MOD_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_sel,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_sel,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_err,
   output logic [2:0]        alu_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_reset,
   input  logic [DATA_W-1:0] alu_result
);

   localparam int unsigned MAX_WAIT = max3(COMB_WAIT, MOD_RST_CYCLES, MOD_WAIT);
   localparam int          CNT_W    = $clog2(MAX_WAIT + 1);

   sched_state_t      r_state;
   sched_state_t      w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last_grant;
   logic [2:0]        r_sel;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_id;
   logic [DATA_W-1:0] r_result;
   logic              r_err;

   logic [1:0]        w_grant;
   logic              w_accept;
   logic              w_gid;
   logic [2:0]        w_sel;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic              w_counting;
   logic              w_cnt_done;
   logic              w_rsp_fire;

   // Gating with reset keeps both readies low while reset is held.
   rr_arbiter_2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .last_grant (r_last_grant),
      .enable     ((r_state == ST_IDLE) && !reset),
      .grant      (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];
   assign w_accept   = |w_grant;
   assign w_gid      = w_grant[1];
   assign w_sel      = w_gid ? req1_sel : req0_sel;
   assign w_a        = w_gid ? req1_a   : req0_a;
   assign w_b        = w_gid ? req1_b   : req0_b;

   assign w_counting = (r_state == ST_ISSUE_COMB) || (r_state == ST_MOD_RST) ||
                       (r_state == ST_MOD_WAIT);
   assign w_cnt_done = (r_cnt == '0);
   assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_sel != ALU_MOD)  w_next = ST_ISSUE_COMB;
               else if (w_b == '0)    w_next = ST_RESP;
               else                   w_next = ST_MOD_RST;
            end
         end
         ST_ISSUE_COMB: if (w_cnt_done) w_next = ST_RESP;
         ST_MOD_RST:    if (w_cnt_done) w_next = ST_MOD_WAIT;
         ST_MOD_WAIT:   if (w_cnt_done) w_next = ST_RESP;
         ST_RESP:       if (w_rsp_fire) w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Counter holds "cycles remaining minus one" so the final count is zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_sel        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= 1'b0;
         r_result     <= '0;
         r_err        <= 1'b0;
      end else if (w_accept) begin
         r_sel        <= w_sel;
         r_a          <= w_a;
         r_b          <= w_b;
         r_id         <= w_gid;
         r_last_grant <= w_gid;
         if (w_sel == ALU_MOD) begin
            r_cnt <= CNT_W'(MOD_RST_CYCLES - 1);
            if (w_b == '0) begin
               r_result <= '1;
               r_err    <= 1'b1;
            end
         end else begin
            r_cnt <= CNT_W'(COMB_WAIT - 1);
         end
      end else if (w_counting) begin
         if (!w_cnt_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end else if (r_state == ST_MOD_RST) begin
            r_cnt <= CNT_W'(MOD_WAIT - 1);
         end else begin
            r_result <= alu_result;
            r_err    <= 1'b0;
         end
      end
   end

   assign alu_sel    = r_sel;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_reset  = (r_state == ST_MOD_RST);
   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: behavioural ALU, scoreboard monitor, table of
// single-requester vectors and hand-written arbitration/backpressure/reset sequences.
module tb_alu_scheduler;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_sel, req1_sel;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0] rsp_result;
   logic [2:0]  alu_sel;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_reset;

   alu_scheduler dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_reset(alu_reset),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: one-cycle registered inputs; mod result valid only
   // after 500 cycles have passed since alu_reset dropped.
   logic [2:0]  m_sel = 3'd0;
   logic [31:0] m_a = 32'd0, m_b = 32'd0;
   int          mod_cnt = 0;

   function automatic logic [31:0] alu_ref(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] b);
      case (s)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_NOR: return ~(a | b);
         ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         default: return (b != 32'd0) ? (a % b) : 32'hFFFF_FFFF;
      endcase
   endfunction

   always @(posedge clk) begin
      m_sel <= alu_sel;
      m_a   <= alu_a;
      m_b   <= alu_b;
      if (alu_reset)           mod_cnt <= 0;
      else if (mod_cnt < 1000) mod_cnt <= mod_cnt + 1;
   end

   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      if (m_sel != ALU_MOD)    alu_result = alu_ref(m_sel, m_a, m_b);
      else if (mod_cnt >= 500) alu_result = alu_ref(m_sel, m_a, m_b);
   end

   // Scoreboard and counters
   typedef struct {
      bit          id;
      logic [31:0] res;
      logic        err;
      logic [2:0]  sel;
      int          e0;
   } exp_t;

   exp_t        sb[$];
   bit          acc_ids[$];
   int          n_acc = 0;
   int          last_acc_edge = 0, last_rsp_edge = 0;
   int          rst_hi_total = 0, rst_run = 0;
   logic [31:0] exp0_res = 32'd0, exp1_res = 32'd0;
   logic        exp0_err = 1'b0, exp1_err = 1'b0;
   int          n_checks = 0, n_errors = 0;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_id = 1'b0, prev_err = 1'b0;
   logic [31:0] prev_res = 32'd0;

   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         rst_run    = 0;
      end else begin
         check_eq("ready_rules", {30'd0, req0_ready & req1_ready,
                                  rsp_valid & (req0_ready | req1_ready)}, 32'd0);
         if (alu_reset) begin
            rst_run++;
            rst_hi_total++;
         end else if (rst_run != 0) begin
            check_eq("alu_reset_len", 32'(rst_run), 32'd4);
            rst_run = 0;
         end
         if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, exp0_res, exp0_err, req0_sel, cyc + 1});
            acc_ids.push_back(1'b0);
            n_acc++;
            last_acc_edge = cyc + 1;
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, exp1_res, exp1_err, req1_sel, cyc + 1});
            acc_ids.push_back(1'b1);
            n_acc++;
            last_acc_edge = cyc + 1;
         end
         if (prev_valid && !prev_ready) begin
            check_eq("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("rsp_hold_result", rsp_result, prev_res);
            check_eq("rsp_hold_id_err", {30'd0, rsp_id, rsp_err}, {30'd0, prev_id, prev_err});
         end
         if (rsp_valid && !prev_valid) begin
            check_eq("rsp_has_request", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
               if (sb[0].err)             check_eq("lat_div0_le1", {31'd0, (cyc - sb[0].e0) <= 1}, 32'd1);
               else if (sb[0].sel == ALU_MOD) check_eq("lat_mod", 32'(cyc - sb[0].e0), 32'd516);
               else                        check_eq("lat_comb", 32'(cyc - sb[0].e0), 32'd2);
            end
         end
         if (rsp_valid && rsp_ready) begin
            last_rsp_edge = cyc + 1;
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
               check_eq("rsp_result", rsp_result, e.res);
               check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
         end
         prev_valid = rsp_valid;
         prev_ready = rsp_ready;
         prev_id    = rsp_id;
         prev_err   = rsp_err;
         prev_res   = rsp_result;
      end
   end

   task automatic req_op(input bit id, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic err);
      bit got = 1'b0;
      int t   = 0;
      if (id == 1'b0) begin
         req0_sel = sel; req0_a = a; req0_b = b;
         exp0_res = res; exp0_err = err; req0_valid = 1'b1;
      end else begin
         req1_sel = sel; req1_a = a; req1_b = b;
         exp1_res = res; exp1_err = err; req1_valid = 1'b1;
      end
      while (!got && t < 2000) begin
         @(negedge clk);
         got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
         t++;
      end
      check_eq("accept_wait", {31'd0, got}, 32'd1);
      @(posedge clk);
      #1;
      if (id == 1'b0) req0_valid = 1'b0;
      else            req1_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int t = 0;
      @(negedge clk);
      while ((sb.size() != 0 || rsp_valid) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          id;
      logic [2:0]  sel;
      logic [31:0] a, b, res;
      logic        err;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          h0, n0, t, highs;
      logic [3:0]  ord4;
      logic [1:0]  ord2;

      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      req0_sel = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_sel = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
      #2;
      check_eq("reset_ctrl", {23'd0, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready,
                              alu_reset, alu_sel}, 32'd0);
      check_eq("reset_data", rsp_result | alu_a | alu_b, 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      tbl[0] = '{1'b0, ALU_ADD, 32'd10, 32'd3, 32'd13,         1'b0};
      tbl[1] = '{1'b1, ALU_MOD, 32'd10, 32'd3, 32'd1,          1'b0};
      tbl[2] = '{1'b0, ALU_MOD, 32'd10, 32'd0, 32'hFFFF_FFFF,  1'b1};
      tbl[3] = '{1'b0, ALU_SLT, 32'd3,  32'd10, 32'd1,         1'b0};
      tbl[4] = '{1'b1, ALU_XOR, 32'd10, 32'd3, 32'd9,          1'b0};

      for (int i = 0; i < 5; i++) begin
         h0 = rst_hi_total;
         req_op(tbl[i].id, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].err);
         wait_drain(700);
         check_eq("alu_reset_cycles", 32'(rst_hi_total - h0),
                  (tbl[i].sel == ALU_MOD && !tbl[i].err) ? 32'd4 : 32'd0);
      end

      // Both requesters contend continuously: grants must alternate 0,1,0,1.
      acc_ids.delete();
      fork
         begin
            req_op(1'b0, ALU_AND, 32'd10, 32'd3, 32'd2, 1'b0);
            req_op(1'b0, ALU_AND, 32'd10, 32'd3, 32'd2, 1'b0);
         end
         begin
            req_op(1'b1, ALU_NOR, 32'd10, 32'd3, 32'hFFFF_FFF4, 1'b0);
            req_op(1'b1, ALU_NOR, 32'd10, 32'd3, 32'hFFFF_FFF4, 1'b0);
         end
      join
      wait_drain(100);
      check_eq("alt_count", 32'(acc_ids.size()), 32'd4);
      ord4 = 4'hF;
      for (int i = 0; i < 4; i++) if (i < acc_ids.size()) ord4[i] = acc_ids[i];
      check_eq("alt_grant_order", {28'd0, ord4}, 32'h0000_000A);

      // Backpressure: hold the sub(10,3) response for 10 cycles with req1 waiting.
      rsp_ready = 1'b0;
      req_op(1'b0, ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0);
      fork
         req_op(1'b1, ALU_OR, 32'd10, 32'd3, 32'd11, 1'b0);
      join_none
      t = 0;
      while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
      check_eq("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      repeat (10) @(negedge clk);
      check_eq("hold_result", rsp_result, 32'd7);
      check_eq("hold_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
      n0 = n_acc;
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      t = 0;
      while (n_acc == n0 && t < 20) begin @(negedge clk); t++; end
      check_eq("accept_after_rsp", 32'(last_acc_edge), 32'(last_rsp_edge + 1));
      wait_drain(100);

      // Reset in the middle of MOD_WAIT aborts without a response.
      req_op(1'b1, ALU_MOD, 32'd10, 32'd3, 32'd1, 1'b0);
      repeat (100) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check_eq("abort_ctrl", {23'd0, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready,
                              alu_reset, alu_sel}, 32'd0);
      check_eq("abort_data", rsp_result | alu_a | alu_b, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      highs = 0;
      repeat (20) begin @(negedge clk); if (rsp_valid) highs++; end
      check_eq("no_rsp_after_abort", 32'(highs), 32'd0);
      @(posedge clk);
      #1;

      // First tie after reset goes to req0.
      acc_ids.delete();
      fork
         req_op(1'b0, ALU_OR,  32'd10, 32'd3, 32'd11, 1'b0);
         req_op(1'b1, ALU_XOR, 32'd10, 32'd3, 32'd9,  1'b0);
      join
      wait_drain(100);
      ord2 = 2'b11;
      for (int i = 0; i < 2; i++) if (i < acc_ids.size()) ord2[i] = acc_ids[i];
      check_eq("post_reset_order", {30'd0, ord2}, 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
